npc_seq: RTL and testbench
==========================

# npc_seq

Multi-cycle control sequencer for the NPC RV32IM core. It fetches each instruction over a request/acknowledge port, latches it, classifies it, and routes it through execute, memory and multiply/divide wait states to a single write-back cycle. That cycle carries the register-file and PC write strobes. It sits between the core datapath (register file, PC, ALU, MDU) and the instruction and data memory ports, and it is the only source of `reg_we` and `pc_we`.

## Interface
- `TIMEOUT`, 255: maximum cycles spent waiting for `imem_ack`, `dmem_ack` or `mdu_done` before entering ERR.
- `START_INSTRET`, 0: value loaded into `instret` on reset.

- `clk` in 1: core clock; all state changes on the rising edge.
- `global_rst` in 1: reset, asynchronous and active-high.
- `imem_req` out 1: instruction fetch request.
- `imem_ack` in 1: fetch complete; `imem_rdata` valid in the same cycle.
- `imem_rdata` in 32: fetched instruction word.
- `inst_q` out 32: latched current instruction; drives datapath decode.
- `dmem_req` out 1: data access request (load/store).
- `dmem_we` out 1: data access is a store; valid while `dmem_req` is high.
- `dmem_ack` in 1: data access complete.
- `mdu_start` out 1: one-cycle start pulse to the multiply/divide unit.
- `mdu_done` in 1: MDU result valid.
- `reg_we` out 1: register-file write strobe.
- `pc_we` out 1: PC update strobe.
- `retire` out 1: one-cycle pulse per completed instruction.
- `instret` out 32: retired-instruction counter.
- `halted` out 1: sticky flag; EBREAK executed.
- `error` out 1: sticky flag; illegal opcode or timeout.
- `state` out 3: current state encoding, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, MDU=4, WB=5, HALT=6, ERR=7.
- **FETCH**
  - `imem_req`=1.
  - On `imem_ack`: `inst_q` <= `imem_rdata`, then go to DECODE.
- **DECODE**: one cycle; the classifier evaluates `inst_q`; go to EXEC.
- **EXEC**: one cycle, branching on the classifier result.
  - Opcode 0000011 (load) or 0100011 (store): go to MEM.
  - Opcode 0110011 with funct7=0000001 (M-extension): go to MDU.
  - `inst_q`==32'h00100073 (EBREAK): go to HALT.
  - Opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111, 1110011}: go to ERR.
  - Any other instruction: go to WB.
- **MEM**
  - `dmem_req`=1.
  - `dmem_we`=1 for store, 0 for load.
  - On `dmem_ack`: go to WB.
- **MDU**
  - `mdu_start`=1 only in the first MDU cycle.
  - `mdu_done` is sampled in every MDU cycle, including the first.
  - On `mdu_done`: go to WB.
- **WB**
  - `pc_we`=1 and `retire`=1.
  - `reg_we`=1 iff opcode ∈ {0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111} and rd≠0.
  - `instret` += 1, wrapping at 2^32.
  - Go to FETCH.
- **HALT / ERR**: absorbing until reset. `halted` / `error` are high; all strobes and requests are 0.
- **Timeout counter**
  - Width $clog2(TIMEOUT+1).
  - Clears on every state change.
  - Increments each cycle spent in FETCH, MEM or MDU without the awaited handshake.
  - When the count reaches TIMEOUT with no handshake: go to ERR.
  - A handshake arriving in the same cycle as the limit wins.
- Outputs are Moore-decoded from `state` and are forced to 0 while `global_rst` is high.

## Timing
- Reset values: `state`=FETCH, `inst_q`=0, `instret`=START_INSTRET, timeout counter=0, `halted`=`error`=0, all strobes and requests 0.
- `imem_req` rises in the first cycle after `global_rst` deasserts.
- ALU/branch/jump instruction with `imem_ack` in the first FETCH cycle: 4 cycles, FETCH→DECODE→EXEC→WB.
- Load/store with immediate `dmem_ack`: 5 cycles.
- M-extension with immediate `mdu_done`: 5 cycles.
- Each wait cycle adds 1.
- A request stays high until its ack; an ack seen outside its owning state is ignored.
- `retire`, `pc_we` and `reg_we` are coincident, exactly one cycle per instruction.
- `global_rst` asserted mid-operation:
  - Return to FETCH immediately, with no WB strobes.
  - An in-flight memory or MDU transaction is abandoned.
  - `instret` reloads.

## Structure
- Package `npc_pkg` holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM);
  - FUNCT7_MULDIV;
  - INST_EBREAK;
  - the 3-bit state enum.
- Sub-module `npc_inst_class`: purely combinational classifier, `inst_q` → {is_mem, is_store, is_mdu, is_ebreak, is_illegal, writes_rd}.
- The FSM, timeout counter and `instret` live in `npc_seq`.

## Test plan
- Reset, then `imem_ack` tied high and `imem_rdata`=32'h00100093 (addi x1,x0,1): `state` sequence 0,1,2,5 repeats; `reg_we`/`pc_we`/`retire` high every 4th cycle; `instret` increments by 1 each time.
- `imem_rdata`=32'h0000A103 (lw x2,0(x1)) with `dmem_ack` delayed 3 cycles: `dmem_req`=1 and `dmem_we`=0 for 4 cycles; WB follows with `reg_we`=1.
- `imem_rdata`=32'h0020A023 (sw x2,0(x1)): `dmem_we`=1 in MEM; `reg_we`=0 in WB; `pc_we`=1 in WB.
- `imem_rdata`=32'h022081B3 (mul x3,x1,x2) with `mdu_done` after 5 cycles: `mdu_start` is a single pulse on the first MDU cycle; WB then has `reg_we`=1.
- Sticky exits:
  - `imem_rdata`=32'h00100073 (EBREAK): `halted`=1 and `state`=6 permanently; `instret` unchanged.
  - `imem_rdata`=32'hFFFFFFFF: `error`=1, `state`=7.
- `TIMEOUT`=4 with `imem_ack` held low: ERR is entered after 4 FETCH cycles. Asserting `global_rst` mid-MEM returns `state` to 0 with no `retire` pulse.

Source files
------------

// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_pkg
// Description : Shared opcode constants, state encoding and instruction class
//               record for the NPC RV32IM control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;

   // RV32 major opcodes (inst[6:0])
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // funct7 that selects the M extension inside OP_R
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   // Full EBREAK encoding
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   // Sequencer states; the encoding is visible on the debug state port
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_MDU    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_ERR    = 3'd7
   } state_t;

   // Classifier result for the latched instruction
   typedef struct packed {
      logic is_mem;
      logic is_store;
      logic is_mdu;
      logic is_ebreak;
      logic is_illegal;
      logic writes_rd;
   } inst_class_t;

endpackage
`default_nettype wire

// File: rtl/npc_inst_class.sv
`default_nettype none
// ============================================================================
// Module      : npc_inst_class
// Description : Purely combinational classifier. Maps the latched instruction
//               word onto the routing flags used by the sequencer FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_inst_class
   import npc_pkg::*;
(
   input  logic [31:0] i_inst,
   output inst_class_t o_class
);

   logic [6:0] w_opcode;
   logic [6:0] w_funct7;
   logic       w_rd_nz;

   assign w_opcode = i_inst[6:0];
   assign w_funct7 = i_inst[31:25];
   assign w_rd_nz  = |i_inst[11:7];

   // Decode opcode into legality, routing and register-write intent
   always_comb begin
      o_class            = '0;
      o_class.is_ebreak  = (i_inst == INST_EBREAK);
      o_class.is_illegal = 1'b0;
      case (w_opcode)
         OP_R: begin
            o_class.is_mdu    = (w_funct7 == FUNCT7_MULDIV);
            o_class.writes_rd = w_rd_nz;
         end
         OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            o_class.writes_rd = w_rd_nz;
         end
         OP_LOAD: begin
            o_class.is_mem    = 1'b1;
            o_class.writes_rd = w_rd_nz;
         end
         OP_STORE: begin
            o_class.is_mem   = 1'b1;
            o_class.is_store = 1'b1;
         end
         OP_BRANCH, OP_SYSTEM: begin
            // legal, but never writes the register file from the sequencer's view
         end
         default: begin
            o_class.is_illegal = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/npc_seq.sv
`default_nettype none
// ============================================================================
// Module      : npc_seq
// Description : Multi-cycle control sequencer for the NPC RV32IM core.
//               Fetch -> decode -> execute -> (memory | mul/div wait) ->
//               single write-back cycle carrying the PC/regfile strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_seq
   import npc_pkg::*;
#(
   parameter int unsigned TIMEOUT       = 255,
   parameter logic [31:0] START_INSTRET = 32'd0
)(
   input  logic        clk,
   input  logic        global_rst,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_q,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        mdu_start,
   input  logic        mdu_done,
   output logic        reg_we,
   output logic        pc_we,
   output logic        retire,
   output logic [31:0] instret,
   output logic        halted,
   output logic        error,
   output logic [2:0]  state
);

   localparam int unsigned          c_TMO_W   = $clog2(TIMEOUT + 1);
   localparam logic [c_TMO_W-1:0]   c_TMO_MAX = c_TMO_W'(TIMEOUT);

   state_t              r_state;
   state_t              w_next_state;
   logic [31:0]         r_inst;
   logic [31:0]         r_instret;
   logic [c_TMO_W-1:0]  r_tmo;
   logic [c_TMO_W-1:0]  w_tmo_inc;
   logic                w_tmo_expire;
   logic                w_waiting;
   inst_class_t         w_class;

   npc_inst_class u_class (
      .i_inst  (r_inst),
      .o_class (w_class)
   );

   assign w_tmo_inc    = r_tmo + c_TMO_W'(1);
   assign w_tmo_expire = (w_tmo_inc == c_TMO_MAX);

   // Next-state logic; an arriving handshake always beats the timeout limit
   always_comb begin
      w_next_state = r_state;
      w_waiting    = 1'b0;
      case (r_state)
         ST_FETCH: begin
            if (imem_ack) begin
               w_next_state = ST_DECODE;
            end else begin
               w_waiting = 1'b1;
               if (w_tmo_expire) w_next_state = ST_ERR;
            end
         end
         ST_DECODE: begin
            w_next_state = ST_EXEC;
         end
         ST_EXEC: begin
            if (w_class.is_mem)          w_next_state = ST_MEM;
            else if (w_class.is_mdu)     w_next_state = ST_MDU;
            else if (w_class.is_ebreak)  w_next_state = ST_HALT;
            else if (w_class.is_illegal) w_next_state = ST_ERR;
            else                         w_next_state = ST_WB;
         end
         ST_MEM: begin
            if (dmem_ack) begin
               w_next_state = ST_WB;
            end else begin
               w_waiting = 1'b1;
               if (w_tmo_expire) w_next_state = ST_ERR;
            end
         end
         ST_MDU: begin
            if (mdu_done) begin
               w_next_state = ST_WB;
            end else begin
               w_waiting = 1'b1;
               if (w_tmo_expire) w_next_state = ST_ERR;
            end
         end
         ST_WB: begin
            w_next_state = ST_FETCH;
         end
         default: begin
            // HALT and ERR are absorbing until reset
            w_next_state = r_state;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) r_state <= ST_FETCH;
      else            r_state <= w_next_state;
   end

   // Wait-cycle counter: cleared on any state change, counts unanswered waits
   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         r_tmo <= '0;
      end else if (w_next_state != r_state) begin
         r_tmo <= '0;
      end else if (w_waiting) begin
         r_tmo <= w_tmo_inc;
      end
   end

   // Instruction latch, loaded on the fetch handshake
   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         r_inst <= 32'd0;
      end else if (r_state == ST_FETCH && imem_ack) begin
         r_inst <= imem_rdata;
      end
   end

   // Retired-instruction counter, bumped once per write-back
   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         r_instret <= START_INSTRET;
      end else if (r_state == ST_WB) begin
         r_instret <= r_instret + 32'd1;
      end
   end

   // Moore output decode; the wait counter is still zero in the first MDU
   // cycle, which makes it a free first-cycle marker for the start pulse
   always_comb begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      mdu_start = 1'b0;
      reg_we    = 1'b0;
      pc_we     = 1'b0;
      retire    = 1'b0;
      halted    = 1'b0;
      error     = 1'b0;
      if (!global_rst) begin
         case (r_state)
            ST_FETCH: imem_req = 1'b1;
            ST_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = w_class.is_store;
            end
            ST_MDU:  mdu_start = (r_tmo == '0);
            ST_WB: begin
               pc_we  = 1'b1;
               retire = 1'b1;
               reg_we = w_class.writes_rd;
            end
            ST_HALT: halted = 1'b1;
            ST_ERR:  error  = 1'b1;
            default: begin
            end
         endcase
      end
   end

   assign inst_q  = r_inst;
   assign instret = r_instret;
   assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_npc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_npc_seq
// Description : Self-checking bench for npc_seq. Table of directed
//               instruction vectors plus hand sequences for reset, sticky
//               exits, the fetch timeout and reset during a memory access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_seq;

   logic        clk = 1'b0;
   logic        global_rst;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        dmem_ack;
   logic        mdu_done;

   logic        imem_req,   dmem_req,   dmem_we,   mdu_start;
   logic        reg_we,     pc_we,      retire,    halted,    error;
   logic [31:0] inst_q,     instret;
   logic [2:0]  state;

   logic        imem_req_t, dmem_req_t, dmem_we_t, mdu_start_t;
   logic        reg_we_t,   pc_we_t,    retire_t,  halted_t,  error_t;
   logic [31:0] inst_q_t,   instret_t;
   logic [2:0]  state_t;

   int n_vec = 0;
   int n_mis = 0;
   int exp_ir;

   always #5 clk = ~clk;

   npc_seq u_dut (
      .clk(clk), .global_rst(global_rst),
      .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst_q(inst_q), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .mdu_start(mdu_start), .mdu_done(mdu_done), .reg_we(reg_we), .pc_we(pc_we),
      .retire(retire), .instret(instret), .halted(halted), .error(error), .state(state)
   );

   // Short-timeout instance sharing the same stimulus
   npc_seq #(.TIMEOUT(4)) u_dut_t (
      .clk(clk), .global_rst(global_rst),
      .imem_req(imem_req_t), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst_q(inst_q_t), .dmem_req(dmem_req_t), .dmem_we(dmem_we_t), .dmem_ack(dmem_ack),
      .mdu_start(mdu_start_t), .mdu_done(mdu_done), .reg_we(reg_we_t), .pc_we(pc_we_t),
      .retire(retire_t), .instret(instret_t), .halted(halted_t), .error(error_t), .state(state_t)
   );

   typedef struct {
      string       name;
      logic [31:0] inst;
      int          dly;
      bit          stray;
      int          exp_cyc;
      logic        exp_rwe;
      int          exp_dreq;
      int          exp_dwe;
      int          exp_ms;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      global_rst = 1'b1;
      imem_ack = 1'b0; dmem_ack = 1'b0; mdu_done = 1'b0;
      repeat (2) @(negedge clk);
      global_rst = 1'b0;
      exp_ir = 0;
   endtask

   // Runs one instruction from a FETCH cycle, acting as memory/MDU responder.
   // Ends on the negedge following WB (back in FETCH) or on HALT/ERR.
   task automatic run_inst(input string nm, input logic [31:0] inst, input int dly,
                           input bit stray, output int cyc, output logic rwe,
                           output logic pwe, output int nreq, output int nwe,
                           output int nms, output int nbad, output logic [2:0] fst);
      int  w;
      bit  done;
      w = 0; done = 0; cyc = 0; rwe = 0; pwe = 0;
      nreq = 0; nwe = 0; nms = 0; nbad = 0; fst = 3'd0;
      imem_rdata = inst;
      for (int k = 0; k < 64; k++) begin
         cyc++;
         fst = state;
         if ((reg_we || pc_we) && !retire) nbad++;
         if (mdu_start) nms++;
         imem_ack = imem_req;
         dmem_ack = stray;
         mdu_done = stray;
         if (dmem_req) begin
            nreq++;
            if (dmem_we) nwe++;
            dmem_ack = (w == dly);
            w++;
         end
         if (state == 3'd4) begin
            mdu_done = (w == dly);
            w++;
         end
         if (retire) begin
            rwe = reg_we;
            pwe = pc_we;
         end
         done = retire || (state == 3'd6) || (state == 3'd7);
         @(negedge clk);
         if (done) break;
      end
      if (!done) chk({nm, " cycle bound"}, 64'd0, 64'd1);
      imem_ack = 1'b0; dmem_ack = 1'b0; mdu_done = 1'b0;
   endtask

   initial begin
      int          cyc, nreq, nwe, nms, nbad, nret;
      logic        rwe, pwe;
      logic [2:0]  fst;
      logic [2:0]  seq [4];

      vecs[0]  = '{"addi",       32'h00100093, 0, 1'b0,  4, 1'b1, 0, 0, 0};
      vecs[1]  = '{"addi_stray", 32'h00100093, 0, 1'b1,  4, 1'b1, 0, 0, 0};
      vecs[2]  = '{"lw_wait3",   32'h0000A103, 3, 1'b0,  8, 1'b1, 4, 0, 0};
      vecs[3]  = '{"sw",         32'h0020A023, 0, 1'b0,  5, 1'b0, 1, 1, 0};
      vecs[4]  = '{"sw_wait2",   32'h0020A023, 2, 1'b0,  7, 1'b0, 3, 3, 0};
      vecs[5]  = '{"mul_wait5",  32'h022081B3, 5, 1'b0, 10, 1'b1, 0, 0, 1};
      vecs[6]  = '{"divu",       32'h0220D233, 0, 1'b0,  5, 1'b1, 0, 0, 1};
      vecs[7]  = '{"beq",        32'h00000063, 0, 1'b0,  4, 1'b0, 0, 0, 0};
      vecs[8]  = '{"nop_rd0",    32'h00000013, 0, 1'b0,  4, 1'b0, 0, 0, 0};
      vecs[9]  = '{"lui",        32'h000002B7, 0, 1'b0,  4, 1'b1, 0, 0, 0};
      vecs[10] = '{"auipc",      32'h00000397, 0, 1'b0,  4, 1'b1, 0, 0, 0};
      vecs[11] = '{"jal",        32'h000000EF, 0, 1'b0,  4, 1'b1, 0, 0, 0};
      vecs[12] = '{"jalr_rd0",   32'h00008067, 0, 1'b0,  4, 1'b0, 0, 0, 0};
      vecs[13] = '{"sub",        32'h402081B3, 0, 1'b0,  4, 1'b1, 0, 0, 0};
      vecs[14] = '{"ecall",      32'h00000073, 0, 1'b0,  4, 1'b0, 0, 0, 0};
      vecs[15] = '{"lw_rd0",     32'h0000A003, 0, 1'b0,  5, 1'b0, 1, 0, 0};

      seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd5;

      // ---------------- reset values ----------------
      global_rst = 1'b1;
      imem_ack = 1'b0; imem_rdata = 32'd0; dmem_ack = 1'b0; mdu_done = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst state",    state,    3'd0);
      chk("rst imem_req", imem_req, 1'b0);
      chk("rst inst_q",   inst_q,   32'd0);
      chk("rst instret",  instret,  32'd0);
      chk("rst strobes",  {reg_we, pc_we, retire, dmem_req, mdu_start}, 5'd0);
      chk("rst sticky",   {halted, error}, 2'd0);
      global_rst = 1'b0;
      exp_ir = 0;
      #1;
      chk("imem_req after rst", imem_req, 1'b1);
      @(negedge clk);
      // that was one FETCH cycle without ack; restart cleanly
      do_reset();

      // ---------------- addi with imem_ack tied high ----------------
      imem_ack = 1'b1;
      imem_rdata = 32'h00100093;
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("addi seq state c%0d", c), state, seq[c % 4]);
         chk($sformatf("addi seq strobes c%0d", c), {retire, pc_we, reg_we},
             (c % 4 == 3) ? 3'b111 : 3'b000);
         @(negedge clk);
      end
      imem_ack = 1'b0;
      exp_ir = 2;
      chk("addi seq instret", instret, 32'd2);
      chk("addi inst_q",      inst_q,  32'h00100093);

      // ---------------- table-driven vectors ----------------
      foreach (vecs[i]) begin
         run_inst(vecs[i].name, vecs[i].inst, vecs[i].dly, vecs[i].stray,
                  cyc, rwe, pwe, nreq, nwe, nms, nbad, fst);
         exp_ir++;
         chk({vecs[i].name, " cycles"},    cyc,  vecs[i].exp_cyc);
         chk({vecs[i].name, " reg_we"},    rwe,  vecs[i].exp_rwe);
         chk({vecs[i].name, " pc_we"},     pwe,  1'b1);
         chk({vecs[i].name, " dmem_req"},  nreq, vecs[i].exp_dreq);
         chk({vecs[i].name, " dmem_we"},   nwe,  vecs[i].exp_dwe);
         chk({vecs[i].name, " mdu_start"}, nms,  vecs[i].exp_ms);
         chk({vecs[i].name, " stray strobe"}, nbad, 0);
         chk({vecs[i].name, " instret"},   instret, exp_ir);
      end

      // ---------------- EBREAK: sticky halt ----------------
      run_inst("ebreak", 32'h00100073, 0, 1'b0, cyc, rwe, pwe, nreq, nwe, nms, nbad, fst);
      chk("ebreak final state", fst, 3'd6);
      imem_ack = 1'b1;
      repeat (5) @(negedge clk);
      chk("halt state",    state,   3'd6);
      chk("halt flags",    {halted, error}, 2'b10);
      chk("halt quiet",    {imem_req, dmem_req, mdu_start, reg_we, pc_we, retire}, 6'd0);
      chk("halt instret",  instret, exp_ir);
      imem_ack = 1'b0;

      // ---------------- illegal opcode: sticky error ----------------
      do_reset();
      run_inst("illegal", 32'hFFFFFFFF, 0, 1'b0, cyc, rwe, pwe, nreq, nwe, nms, nbad, fst);
      chk("illegal final state", fst, 3'd7);
      repeat (3) @(negedge clk);
      chk("err state",   state, 3'd7);
      chk("err flags",   {halted, error}, 2'b01);
      chk("err instret", instret, 32'd0);

      // ---------------- fetch timeout (TIMEOUT=4 instance) ----------------
      do_reset();
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("tmo fetch c%0d", c), state_t, 3'd0);
         @(negedge clk);
      end
      chk("tmo err state", state_t, 3'd7);
      chk("tmo err flag",  error_t, 1'b1);
      chk("tmo default still fetching", state, 3'd0);

      // ack in the same cycle as the limit wins
      do_reset();
      repeat (3) @(negedge clk);
      imem_rdata = 32'h00100093;
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("tmo ack at limit", state_t, 3'd1);

      // ---------------- reset in the middle of MEM ----------------
      do_reset();
      run_inst("pre addi", 32'h00100093, 0, 1'b0, cyc, rwe, pwe, nreq, nwe, nms, nbad, fst);
      chk("pre addi instret", instret, 32'd1);
      imem_rdata = 32'h0000A103;
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid mem state", state, 3'd3);
      @(negedge clk);
      #2 global_rst = 1'b1;
      #1;
      chk("async rst state",  state,    3'd0);
      chk("async rst quiet",  {dmem_req, retire, pc_we, reg_we}, 4'd0);
      chk("async rst instret", instret, 32'd0);
      @(negedge clk);
      global_rst = 1'b0;
      dmem_ack = 1'b1;
      nret = 0;
      for (int c = 0; c < 6; c++) begin
         if (retire) nret++;
         @(negedge clk);
      end
      dmem_ack = 1'b0;
      chk("no retire after rst", nret, 0);
      chk("post rst state", state, 3'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
